// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and redirect FSM state type
package pipe_pkg;
  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] NPC_SEQ = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } redir_state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && !(&q_q)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/pipe_redirect_ctrl.sv
// rtl/pipe_redirect_ctrl.sv - EX-stage branch redirect/flush controller with stall hold and stats
module pipe_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int N_FLUSH = 2,
  parameter int REG_OUT = 0,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [SEL_W-1:0]   br_sel,
  input  logic [XLEN-1:0]    br_pred_pc,
  input  logic [XLEN-1:0]    br_npc,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [N_FLUSH-1:0] flush_vec,
  output logic               pending,
  output logic [CNT_W-1:0]   branch_cnt,
  output logic [CNT_W-1:0]   mispredict_cnt
);
  redir_state_t    state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            mis;
  logic            issue;
  logic [XLEN-1:0] issue_pc;
  logic            branch_inc;

  assign mis        = en & br_valid & (br_sel != NPC_SEQ) & (br_pred_pc != br_npc);
  assign branch_inc = en & br_valid & (br_sel != NPC_SEQ) & !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // HOLD ignores EX entirely: the frozen instruction must not be detected twice.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    issue    = 1'b0;
    issue_pc = '0;
    case (state_q)
      IDLE: begin
        if (mis) begin
          if (stall) begin
            state_d = HOLD;
            tgt_d   = br_npc;
          end else begin
            issue    = 1'b1;
            issue_pc = br_npc;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          issue    = 1'b1;
          issue_pc = tgt_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      issue    = 1'b0;
      issue_pc = '0;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic            rv_q;
      logic [XLEN-1:0] pc_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rv_q <= 1'b0;
          pc_q <= '0;
        end else begin
          rv_q <= issue;
          pc_q <= issue_pc;
        end
      end

      // Registered pulse is masked while rst is held so outputs read 0 during reset.
      assign redirect_valid = rv_q & !rst;
      assign redirect_pc    = rst ? '0 : pc_q;
    end else begin : g_comb_out
      assign redirect_valid = issue;
      assign redirect_pc    = issue_pc;
    end
  endgenerate

  assign flush_vec = {N_FLUSH{redirect_valid}};
  assign pending   = (state_q == HOLD) & !rst;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch_inc),
    .q   (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (issue),
    .q   (mispredict_cnt)
  );
endmodule

// File: doc/pipe_redirect_ctrl.md
# pipe_redirect_ctrl

Parametrised branch-redirect and flush controller for the five-stage LA32R pipeline. It sits beside the EX stage. It compares each resolved control-transfer target against the PC the front end actually fetched. On a mismatch it issues one redirect to the PC mux and one flush pulse per front-end pipeline register. Unlike the single-cycle combinational flush, it holds a pending redirect across back-end stalls, can drive flush from a registered path, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `N_FLUSH`, 2, number of front-end pipeline registers to flush (bit 0 = IF/ID, bit 1 = ID/EX, …); range 1–4.
- `REG_OUT`, 0: 0 = redirect/flush driven in the issue cycle; 1 = driven one cycle later from flops.
- `CNT_W`, 32, statistics counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global enable; when 0, no detection and counters hold.
- `stall` in 1: back-end stall; pipeline registers frozen this cycle.
- `br_valid` in 1: EX holds a valid instruction this cycle.
- `br_sel` in 2: npc select of the EX instruction; 2'b00 = sequential, otherwise a control transfer.
- `br_pred_pc` in XLEN: PC fetched after the EX instruction (pc+4 under static not-taken).
- `br_npc` in XLEN: resolved next PC.
- `redirect_valid` out 1: load `redirect_pc` into the PC register.
- `redirect_pc` out XLEN: redirect target.
- `flush_vec` out N_FLUSH: per-register flush, all bits equal when asserted.
- `pending` out 1: a redirect is latched and waiting for the stall to drop.
- `branch_cnt` out CNT_W: resolved control transfers.
- `mispredict_cnt` out CNT_W: issued redirects.

## Operation
- `mis` = `en & br_valid & (br_sel != 0) & (br_pred_pc != br_npc)`. This is a full XLEN compare. A sequential `br_sel` never mispredicts.
- FSM states:
  - IDLE:
    - `mis & !stall`: issue the redirect with `br_npc`; stay in IDLE.
    - `mis & stall`: latch `br_npc` into `tgt_q`; go to HOLD.
  - HOLD:
    - `pending` = 1.
    - EX inputs are ignored; the frozen instruction is not re-evaluated.
    - First cycle with `!stall`: issue the redirect with `tgt_q`; go to IDLE.
    - `en` falling in HOLD does not cancel the pending redirect.
- Issue means `redirect_valid` = 1, `flush_vec` = all ones, `redirect_pc` = target, for exactly one cycle (REG_OUT=0) or the following cycle (REG_OUT=1). `redirect_valid` and `flush_vec` are never asserted while `stall` = 1 in REG_OUT=0.
- Idle output values: `redirect_valid` = 0, `flush_vec` = 0, `redirect_pc` = 0.
- Counters:
  - `branch_cnt` +1 when `en & br_valid & br_sel != 0 & !stall`, so a stalled branch counts once.
  - `mispredict_cnt` +1 per issue.
  - Both saturate at all ones.
- Simultaneous events:
  - HOLD exit cycle: the EX contents are still the frozen instruction; no new detection occurs that cycle.
  - The cycle after an issue: EX holds a flushed bubble (`br_valid` = 0), so no back-to-back redirects are possible.

## Timing
- REG_OUT=0: mispredict in cycle T with `!stall` gives the redirect in T, combinational from inputs.
- REG_OUT=1: the redirect appears in T+1. A stall rising in T+1 does not suppress the registered pulse; the PC/flush logic must accept it.
- A stall spanning cycles T..T+k gives the redirect in T+k+1 (+1 more with REG_OUT=1).
- Reset, while `rst` = 1 and the following cycle:
  - FSM = IDLE, `tgt_q` = 0, counters = 0.
  - All outputs 0, including combinational outputs during `rst`.
  - Reset in HOLD discards the pending redirect.

## Structure
- Shared package `pipe_pkg`:
  - `NPC_SEQ` = 2'b00.
  - FSM state typedef `redir_state_t` {IDLE, HOLD}.
  - Width of `br_sel`.
- One sub-module, `sat_counter` (params `W`; ports `clk`, `rst`, `inc`, `q`), instantiated twice.

## Test plan
- Taken branch, `br_pred_pc`=0x1C000004, `br_npc`=0x1C000040, no stall, REG_OUT=0 → `redirect_valid`=1, `redirect_pc`=0x1C000040, `flush_vec`=2'b11 same cycle only; `mispredict_cnt`=1, `branch_cnt`=1.
- Correctly predicted branch (`br_sel`=2'b01, `br_pred_pc` = `br_npc` = 0x1C000008), then `br_sel`=2'b00 with mismatched PCs → no redirect either case; `branch_cnt`=1.
- Mispredict with `stall` high 3 cycles → `pending`=1 for 3 cycles, `branch_cnt` unchanged, redirect to latched target in the 4th cycle; changing `br_npc` during the stall has no effect.
- REG_OUT=1 mispredict at T → outputs 0 in T, redirect pulse in T+1 only.
- `rst` asserted in HOLD → no redirect after reset, counters 0, `pending`=0.
- CNT_W=4: 16 mispredicts → `mispredict_cnt` saturates at 4'hF, no wrap.
